// File: rtl/rand_fp_read_requester.sv
// Read requester for the random FP memory: generates LFSR addresses, issues a read,
// captures the returned elements and offers them downstream with valid/ready.
module rand_fp_read_requester #(
    parameter int unsigned NO_OF_RAND_ELEMENTS = 16,
    parameter int unsigned ELEMENT_WIDTH       = 32,
    parameter int unsigned TIMEOUT_CYCLES      = 1024
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [7:0]                                   seed,
    output logic                                         busy,
    output logic                                         read_mem,
    output logic [8*NO_OF_RAND_ELEMENTS-1:0]             addresses,
    input  logic [ELEMENT_WIDTH*NO_OF_RAND_ELEMENTS-1:0] mem_elements,
    input  logic                                         mem_finish,
    output logic [ELEMENT_WIDTH*NO_OF_RAND_ELEMENTS-1:0] elements,
    output logic                                         elements_valid,
    input  logic                                         elements_ready,
    output logic                                         timeout_err
);

    localparam int unsigned IdxW = (NO_OF_RAND_ELEMENTS > 1) ? $clog2(NO_OF_RAND_ELEMENTS) : 1;
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned AddrW = 8 * NO_OF_RAND_ELEMENTS;
    localparam int unsigned DataW = ELEMENT_WIDTH * NO_OF_RAND_ELEMENTS;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NO_OF_RAND_ELEMENTS - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StReq,
        StWait,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [DataW-1:0]  elem_q, elem_d;
    logic              read_mem_q, read_mem_d;
    logic              valid_q, valid_d;
    logic              tout_q, tout_d;
    logic [7:0]        lfsr_next;

    // Fibonacci LFSR step; a zero seed is replaced on load so the lock-up state never occurs
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Next-state and datapath updates for the request sequence
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        elem_d     = elem_q;
        read_mem_d = read_mem_q;
        valid_d    = valid_q;
        tout_d     = tout_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
                    tout_d  = 1'b0;
                    idx_d   = '0;
                    state_d = StGen;
                end
            end
            StGen: begin
                addr_d[8*idx_q +: 8] = lfsr_q;
                lfsr_d = lfsr_next;
                if (idx_q == LastIdx) begin
                    state_d = StReq;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StReq: begin
                read_mem_d = 1'b1;
                cnt_d      = '0;
                state_d    = StWait;
            end
            StWait: begin
                // Completion takes priority over a timeout in the same cycle
                if (mem_finish) begin
                    elem_d     = mem_elements;
                    read_mem_d = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = StHold;
                end else if (cnt_q == LastCnt) begin
                    read_mem_d = 1'b0;
                    tout_d     = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (elements_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lfsr_q     <= 8'h01;
            idx_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            elem_q     <= '0;
            read_mem_q <= 1'b0;
            valid_q    <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            elem_q     <= elem_d;
            read_mem_q <= read_mem_d;
            valid_q    <= valid_d;
            tout_q     <= tout_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign read_mem       = read_mem_q;
    assign addresses      = addr_q;
    assign elements       = elem_q;
    assign elements_valid = valid_q;
    assign timeout_err    = tout_q;

endmodule

// File: tb/tb_rand_fp_read_requester.sv
// Self-checking bench for rand_fp_read_requester: table of directed requests, a mid-request
// reset sequence and randomized requests, all checked cycle by cycle against a timing model.
module tb_rand_fp_read_requester;

    localparam int N  = 16;
    localparam int W  = 32;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       seed;
    logic             busy;
    logic             read_mem;
    logic [8*N-1:0]   addresses;
    logic [W*N-1:0]   mem_elements;
    logic             mem_finish;
    logic [W*N-1:0]   elements;
    logic             elements_valid;
    logic             elements_ready;
    logic             timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    // What the elements register should currently hold
    logic [W*N-1:0] exp_elems;

    rand_fp_read_requester #(
        .NO_OF_RAND_ELEMENTS(N),
        .ELEMENT_WIDTH      (W),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .seed          (seed),
        .busy          (busy),
        .read_mem      (read_mem),
        .addresses     (addresses),
        .mem_elements  (mem_elements),
        .mem_finish    (mem_finish),
        .elements      (elements),
        .elements_valid(elements_valid),
        .elements_ready(elements_ready),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seed;
        int         lat;    // cycles from read_mem rising to mem_finish rising
        int         rdy;    // cycles valid is held before ready rises
        bit         noisy;  // random start/seed/mem_finish/ready where they must be ignored
        bit         exp_to;
        logic [7:0] a0;
        logic [7:0] a5;
    } vec_t;

    vec_t tbl[7];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [8*N-1:0] model_addrs(input logic [7:0] s);
        logic [8*N-1:0] r;
        logic [7:0]     a;
        a = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < N; i++) begin
            r[8*i +: 8] = a;
            a = lfsr_step(a);
        end
        return r;
    endfunction

    // One complete request, entered and left at a falling edge; every cycle checked.
    task automatic run_req(input logic [7:0] s, input int lat, input int rdy, input bit noisy,
                           input logic [W*N-1:0] data, output bit got_to,
                           output logic [8*N-1:0] got_addr);
        bit             timed_out;
        int             v;
        int             fin;
        int             rm_last;
        logic [8*N-1:0] ea;

        // Memory answers in time only if its latency fits inside the WAIT budget
        timed_out = (lat >= TO);
        v         = N + 3 + lat;
        fin       = timed_out ? (N + 2 + TO) : (v + rdy + 1);
        rm_last   = timed_out ? (N + 1 + TO) : (v - 1);
        ea        = model_addrs(s);
        got_to    = 1'b0;
        got_addr  = '0;

        start          = 1'b1;
        seed           = s;
        mem_elements   = data;
        mem_finish     = 1'b0;
        elements_ready = 1'b0;

        for (int k = 1; k <= fin; k++) begin
            @(posedge clk);
            #1;
            start = (noisy && k < fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) seed = 8'($urandom);
            if (k >= N + 2 + lat) mem_finish = 1'b1;
            else if (noisy && k <= N + 1) mem_finish = 1'($urandom_range(0, 1));
            else mem_finish = 1'b0;
            if (!timed_out && k >= v + rdy) elements_ready = 1'b1;
            else if (noisy && k < v) elements_ready = 1'($urandom_range(0, 1));
            else elements_ready = 1'b0;

            @(negedge clk);
            chk1("busy", busy, k < fin);
            chk1("read_mem", read_mem, (k >= N + 2) && (k <= rm_last));
            chk1("elements_valid", elements_valid, !timed_out && k >= v && k < fin);
            chk1("timeout_err", timeout_err, (k == fin) ? timed_out : 1'b0);
            if (k == N + 1) begin
                chkw("addresses", 512'(addresses), 512'(ea));
                got_addr = addresses;
            end
            if (!timed_out && k >= v && k < fin) chkw("elements_hold", 512'(elements), 512'(data));
            if (k == fin) begin
                chkw("addresses_end", 512'(addresses), 512'(ea));
                if (!timed_out) exp_elems = data;
                chkw("elements_end", 512'(elements), 512'(exp_elems));
                got_to = timeout_err;
            end
        end
        start          = 1'b0;
        mem_finish     = 1'b0;
        elements_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_read_mem"}, read_mem, 1'b0);
        chk1({tag, "_valid"}, elements_valid, 1'b0);
        chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
        chkw({tag, "_addresses"}, 512'(addresses), 512'(0));
        chkw({tag, "_elements"}, 512'(elements), 512'(0));
    endtask

    function automatic logic [W*N-1:0] rand_data();
        logic [W*N-1:0] d;
        for (int i = 0; i < N; i++) d[W*i +: W] = $urandom;
        return d;
    endfunction

    initial begin
        logic [W*N-1:0] ramp;
        logic [8*N-1:0] ga;
        bit             gt;

        tbl[0] = '{seed: 8'h01, lat: 5,  rdy: 4, noisy: 1'b0, exp_to: 1'b0, a0: 8'h01, a5: 8'h23};
        tbl[1] = '{seed: 8'h00, lat: 2,  rdy: 0, noisy: 1'b0, exp_to: 1'b0, a0: 8'h01, a5: 8'h23};
        tbl[2] = '{seed: 8'hFF, lat: 12, rdy: 0, noisy: 1'b0, exp_to: 1'b1, a0: 8'hFF, a5: 8'hE1};
        tbl[3] = '{seed: 8'h80, lat: 3,  rdy: 1, noisy: 1'b1, exp_to: 1'b0, a0: 8'h80, a5: 8'h11};
        tbl[4] = '{seed: 8'h01, lat: 7,  rdy: 2, noisy: 1'b1, exp_to: 1'b0, a0: 8'h01, a5: 8'h23};
        tbl[5] = '{seed: 8'h01, lat: 8,  rdy: 0, noisy: 1'b0, exp_to: 1'b1, a0: 8'h01, a5: 8'h23};
        tbl[6] = '{seed: 8'h80, lat: 0,  rdy: 3, noisy: 1'b1, exp_to: 1'b0, a0: 8'h80, a5: 8'h11};

        for (int i = 0; i < N; i++) ramp[W*i +: W] = 32'h3F80_0000 + i;

        rst            = 1'b1;
        start          = 1'b0;
        seed           = 8'h00;
        mem_elements   = '0;
        mem_finish     = 1'b0;
        elements_ready = 1'b0;
        exp_elems      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_req(tbl[i].seed, tbl[i].lat, tbl[i].rdy, tbl[i].noisy,
                    (i == 0) ? ramp : rand_data(), gt, ga);
            chk1("tbl_timeout", gt, tbl[i].exp_to);
            chkw("tbl_addr0", 512'(ga[7:0]), 512'(tbl[i].a0));
            chkw("tbl_addr5", 512'(ga[47:40]), 512'(tbl[i].a5));
        end

        // Reset held three cycles in the middle of address generation
        start = 1'b1;
        seed  = 8'h55;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk1("midgen_busy", busy, 1'b1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("midgen_reset");
        rst       = 1'b0;
        exp_elems = '0;
        run_req(8'h01, 4, 1, 1'b0, ramp, gt, ga);
        chkw("restart_addr0", 512'(ga[7:0]), 512'(8'h01));

        // Randomized requests
        for (int r = 0; r < 20; r++) begin
            run_req(8'($urandom), $urandom_range(0, 10), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), rand_data(), gt, ga);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
